sram_port_ctrl: RTL and testbench
=================================

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, SRAM word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-003 The block SHALL have parameter NUM_WMASKS, default 4, byte-lane write mask width (DATA_WIDTH/8).
REQ-004 The block SHALL have parameter INIT_ZERO, default 1, meaning zero-fill all words after reset.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk_i  input  1  clock, all logic on rising edge; also clocks the macro ports clk0/clk1.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 Port 0 request side: req_valid_i  input  1; req_ready_o  output  1; req_we_i  input  1 (1=write); req_addr_i  input  ADDR_WIDTH; req_wdata_i  input  DATA_WIDTH; req_be_i  input  NUM_WMASKS.
REQ-008 Port 0 response side: rsp_valid_o  output  1, one-cycle pulse for read data or write ack; rsp_we_o  output  1; rsp_rdata_o  output  DATA_WIDTH.
REQ-009 Port 1 read-only side: rd1_valid_i  input  1; rd1_ready_o  output  1; rd1_addr_i  input  ADDR_WIDTH; rd1_rsp_valid_o  output  1; rd1_rdata_o  output  DATA_WIDTH.
REQ-010 Macro side, all outputs registered: sram_csb0_o, sram_web0_o  output  1; sram_wmask0_o  output  NUM_WMASKS; sram_addr0_o  output  ADDR_WIDTH; sram_din0_o  output  DATA_WIDTH; sram_dout0_i  input  DATA_WIDTH; sram_csb1_o  output  1; sram_addr1_o  output  ADDR_WIDTH; sram_dout1_i  input  DATA_WIDTH.
REQ-011 init_done_o  output  1  high once the block is in RUN.

Function
REQ-012 FSM states SHALL be INIT and RUN; INIT is entered on reset when INIT_ZERO=1, otherwise RUN.
REQ-013 In INIT, a counter SHALL issue one write per cycle on port 0 with addr=counter, din=0, wmask=all ones, counting 0 to 2^ADDR_WIDTH-1, then move to RUN on the cycle after the last write issues.
REQ-014 In INIT: req_ready_o=0, rd1_ready_o=0, init_done_o=0, sram_csb1_o=1, and no response SHALL pulse.
REQ-015 In RUN: req_ready_o=1 every cycle, so port 0 accepts one request per cycle with no response backpressure.
REQ-016 A port 0 request accepted at edge E0 SHALL drive the macro pins from E0 to E1: csb0=0, web0=!we, addr0=addr, din0=wdata, wmask0=be for a write and all ones for a read.
REQ-017 Cycles with no port 0 request SHALL drive sram_csb0_o=1, sram_web0_o=1, sram_wmask0_o=0; addr0 and din0 SHALL hold their values.
REQ-018 Port 0 read: rsp_rdata_o SHALL capture sram_dout0_i at E2, and rsp_valid_o=1 with rsp_we_o=0 SHALL show during the cycle after E2; latency is 2 cycles, responses in order.
REQ-019 Port 0 write: rsp_valid_o=1 with rsp_we_o=1 SHALL show in the same relative slot as a read (cycle after E2); rsp_rdata_o SHALL hold its previous value.
REQ-020 A write with be=0 SHALL be accepted, SHALL drive csb0=1 (no macro access), and SHALL still be acknowledged.
REQ-021 Port 1 SHALL behave like a port 0 read: accept at E0, csb1=0 and addr1 for one cycle, capture sram_dout1_i at E2, rd1_rsp_valid_o pulse in the following cycle.
REQ-022 Collision: if port 0 accepts a write with be!=0 and rd1_valid_i is high with rd1_addr_i==req_addr_i in the same cycle, rd1_ready_o SHALL be 0 for that cycle; port 1 proceeds on the next cycle and returns the new data.
REQ-023 Port 0 read and port 1 read to the same address in the same cycle SHALL both be accepted.
REQ-024 Address arithmetic SHALL be unsigned ADDR_WIDTH bits; the INIT counter wraps only on termination.

Reset
REQ-025 On rst_ni low, asynchronously: csb0=1, csb1=1, web0=1, wmask0=0, addr0=0, addr1=0, din0=0, rsp_valid_o=0, rd1_rsp_valid_o=0, rsp_we_o=0, rsp_rdata_o=0, rd1_rdata_o=0, init_done_o=0, counter=0.
REQ-026 Reset asserted mid-INIT or mid-transaction SHALL abort all in-flight responses (no pulse after release), and INIT SHALL restart at address 0.

Verification
REQ-027 Reset release with INIT_ZERO=1 -> 1024 consecutive writes to addresses 0..1023 with din=0 and wmask=4'hF; init_done_o rises the following cycle; a read of address 0x155 then returns 0.
REQ-028 Write 0x12345678 to 0x3FF with be=4'hF, then write 0xAA with be=4'b0001, then read 0x3FF -> rsp_rdata_o=0x123456AA, 2-cycle latency, two write acks then one read response.
REQ-029 Back-to-back reads of addresses 1,2,3 on consecutive cycles -> three consecutive rsp_valid_o pulses in order.
REQ-030 Port 0 write 0xDEADBEEF to 0x010 and port 1 read of 0x010 in the same cycle -> rd1_ready_o=0 for one cycle; port 1 then returns 0xDEADBEEF.
REQ-031 Write with be=0 -> sram_csb0_o stays 1 and rsp_valid_o pulses with rsp_we_o=1.
REQ-032 rst_ni pulsed low at INIT count 500 -> outputs at reset values immediately; INIT restarts at address 0.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// Two-port SRAM macro controller: port 0 read/write, port 1 read-only,
// with optional zero-fill of the whole array after reset.
module sram_port_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WMASKS = 4,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // port 0 request
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [NUM_WMASKS-1:0] req_be_i,
  // port 0 response
  output logic                  rsp_valid_o,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  // port 1 read-only
  input  logic                  rd1_valid_i,
  output logic                  rd1_ready_o,
  input  logic [ADDR_WIDTH-1:0] rd1_addr_i,
  output logic                  rd1_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rd1_rdata_o,
  // macro side
  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [NUM_WMASKS-1:0] sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  input  logic [DATA_WIDTH-1:0] sram_dout0_i,
  output logic                  sram_csb1_o,
  output logic [ADDR_WIDTH-1:0] sram_addr1_o,
  input  logic [DATA_WIDTH-1:0] sram_dout1_i,
  output logic                  init_done_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_last_q, init_last_d;
  logic                    init_done_q, init_done_d;

  logic                    csb0_q, csb0_d;
  logic                    web0_q, web0_d;
  logic [NUM_WMASKS-1:0]   wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0]   addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0]   din0_q, din0_d;
  logic                    csb1_q, csb1_d;
  logic [ADDR_WIDTH-1:0]   addr1_q, addr1_d;

  logic                    p0_vld1_q, p0_vld1_d;
  logic                    p0_we1_q, p0_we1_d;
  logic                    p0_vld2_q, p0_vld2_d;
  logic                    p0_we2_q, p0_we2_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_we_q, rsp_we_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                    p1_vld1_q, p1_vld1_d;
  logic                    p1_vld2_q, p1_vld2_d;
  logic                    rd1_rsp_valid_q, rd1_rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rd1_rdata_q, rd1_rdata_d;

  logic                    req_fire_c;
  logic                    wr_active_c;
  logic                    collide_c;
  logic                    rd1_ready_c;
  logic                    rd1_fire_c;

  // A port 1 read hitting the address being written this cycle waits one
  // cycle so it samples the array after the write lands.
  assign req_fire_c  = req_valid_i & init_done_q;
  assign wr_active_c = req_fire_c & req_we_i & (req_be_i != '0);
  assign collide_c   = wr_active_c & rd1_valid_i & (rd1_addr_i == req_addr_i);
  assign rd1_ready_c = init_done_q & ~collide_c;
  assign rd1_fire_c  = rd1_valid_i & rd1_ready_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT_ZERO ? ST_INIT : ST_RUN;
      cnt_q       <= '0;
      init_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_last_q <= init_last_d;
    end
  end

  // RUN is entered one cycle after the final zero-fill write is issued.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_last_d = init_last_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_last_q) begin
          state_d     = ST_RUN;
          init_last_d = 1'b0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == ADDR_LAST) begin
            init_last_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    init_done_d     = (state_d == ST_RUN);
    csb0_d          = 1'b1;
    web0_d          = 1'b1;
    wmask0_d        = '0;
    addr0_d         = addr0_q;
    din0_d          = din0_q;
    csb1_d          = 1'b1;
    addr1_d         = addr1_q;
    p0_vld1_d       = 1'b0;
    p0_we1_d        = 1'b0;
    p1_vld1_d       = 1'b0;
    p0_vld2_d       = p0_vld1_q;
    p0_we2_d        = p0_we1_q;
    p1_vld2_d       = p1_vld1_q;
    rsp_valid_d     = p0_vld2_q;
    rsp_we_d        = p0_vld2_q & p0_we2_q;
    rsp_rdata_d     = (p0_vld2_q && !p0_we2_q) ? sram_dout0_i : rsp_rdata_q;
    rd1_rsp_valid_d = p1_vld2_q;
    rd1_rdata_d     = p1_vld2_q ? sram_dout1_i : rd1_rdata_q;

    if (state_q == ST_INIT && !init_last_q) begin
      csb0_d   = 1'b0;
      web0_d   = 1'b0;
      wmask0_d = '1;
      addr0_d  = cnt_q;
      din0_d   = '0;
    end

    // Zero-byte-enable writes are acknowledged without touching the macro.
    if (req_fire_c) begin
      p0_vld1_d = 1'b1;
      p0_we1_d  = req_we_i;
      addr0_d   = req_addr_i;
      din0_d    = req_wdata_i;
      if (!req_we_i) begin
        csb0_d   = 1'b0;
        wmask0_d = '1;
      end else if (wr_active_c) begin
        csb0_d   = 1'b0;
        web0_d   = 1'b0;
        wmask0_d = req_be_i;
      end
    end

    if (rd1_fire_c) begin
      csb1_d    = 1'b0;
      addr1_d   = rd1_addr_i;
      p1_vld1_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_done_q     <= 1'b0;
      csb0_q          <= 1'b1;
      web0_q          <= 1'b1;
      wmask0_q        <= '0;
      addr0_q         <= '0;
      din0_q          <= '0;
      csb1_q          <= 1'b1;
      addr1_q         <= '0;
      p0_vld1_q       <= 1'b0;
      p0_we1_q        <= 1'b0;
      p0_vld2_q       <= 1'b0;
      p0_we2_q        <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_we_q        <= 1'b0;
      rsp_rdata_q     <= '0;
      p1_vld1_q       <= 1'b0;
      p1_vld2_q       <= 1'b0;
      rd1_rsp_valid_q <= 1'b0;
      rd1_rdata_q     <= '0;
    end else begin
      init_done_q     <= init_done_d;
      csb0_q          <= csb0_d;
      web0_q          <= web0_d;
      wmask0_q        <= wmask0_d;
      addr0_q         <= addr0_d;
      din0_q          <= din0_d;
      csb1_q          <= csb1_d;
      addr1_q         <= addr1_d;
      p0_vld1_q       <= p0_vld1_d;
      p0_we1_q        <= p0_we1_d;
      p0_vld2_q       <= p0_vld2_d;
      p0_we2_q        <= p0_we2_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_we_q        <= rsp_we_d;
      rsp_rdata_q     <= rsp_rdata_d;
      p1_vld1_q       <= p1_vld1_d;
      p1_vld2_q       <= p1_vld2_d;
      rd1_rsp_valid_q <= rd1_rsp_valid_d;
      rd1_rdata_q     <= rd1_rdata_d;
    end
  end

  assign req_ready_o     = init_done_q;
  assign rd1_ready_o     = rd1_ready_c;
  assign init_done_o     = init_done_q;
  assign sram_csb0_o     = csb0_q;
  assign sram_web0_o     = web0_q;
  assign sram_wmask0_o   = wmask0_q;
  assign sram_addr0_o    = addr0_q;
  assign sram_din0_o     = din0_q;
  assign sram_csb1_o     = csb1_q;
  assign sram_addr1_o    = addr1_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_we_o        = rsp_we_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rd1_rsp_valid_o = rd1_rsp_valid_q;
  assign rd1_rdata_o     = rd1_rdata_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural 1RW+1R SRAM macro.
module tb_sram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_we;
  logic [31:0] rsp_rdata;
  logic        rd1_valid = 1'b0;
  logic [9:0]  rd1_addr = '0;
  logic        rd1_ready, rd1_rsp_valid;
  logic [31:0] rd1_rdata;
  logic        csb0, web0, csb1, init_done;
  logic [3:0]  wmask0;
  logic [9:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [126:0] RST_VEC = {3'b111, 124'h0};

  sram_port_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_we_o(rsp_we), .rsp_rdata_o(rsp_rdata),
    .rd1_valid_i(rd1_valid), .rd1_ready_o(rd1_ready), .rd1_addr_i(rd1_addr),
    .rd1_rsp_valid_o(rd1_rsp_valid), .rd1_rdata_o(rd1_rdata),
    .sram_csb0_o(csb0), .sram_web0_o(web0), .sram_wmask0_o(wmask0),
    .sram_addr0_o(addr0), .sram_din0_o(din0), .sram_dout0_i(dout0),
    .sram_csb1_o(csb1), .sram_addr1_o(addr1), .sram_dout1_i(dout1),
    .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  // Macro model: preloaded with non-zero garbage so zero-fill is observable.
  logic [31:0] mem [1024];
  initial begin
    dout0 = '0;
    dout1 = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | i;
    forever begin
      @(posedge clk);
      if (!csb0) begin
        if (!web0) begin
          for (int b = 0; b < 4; b++)
            if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
        end else begin
          dout0 <= mem[addr0];
        end
      end
      if (!csb1) dout1 <= mem[addr1];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [126:0] rst_obs();
    return {csb0, csb1, web0, wmask0, addr0, addr1, din0, rsp_valid,
            rd1_rsp_valid, rsp_we, rsp_rdata, rd1_rdata, init_done};
  endfunction

  task automatic p0_req(input logic we, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
  endtask

  task automatic p0_idle;
    req_valid = 1'b0; req_we = 1'b0; req_be = '0;
  endtask

  task automatic test_reset;
    logic [126:0] obs;
    rst_n = 1'b0;
    tick; tick;
    obs = rst_obs();
    n_checks++;
    if (obs !== RST_VEC) begin
      n_errors++; $display("FAIL reset_vals: got %h expected %h", obs, RST_VEC);
    end
    n_checks++;
    if ({req_ready, rd1_ready} !== 2'b00) begin
      n_errors++; $display("FAIL reset_ready: got %b expected 00", {req_ready, rd1_ready});
    end
  endtask

  task automatic test_init;
    int wr = 0, last_i = -1, done_i = -1, bad = 0;
    logic csb0_at_done = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      tick;
      if (init_done === 1'b1) begin done_i = i; csb0_at_done = csb0; break; end
      if (csb0 === 1'b0) begin
        if (web0 !== 1'b0 || wmask0 !== 4'hF || din0 !== 32'h0 || addr0 !== 10'(wr)) bad++;
        wr++; last_i = i;
      end
      if (req_ready !== 1'b0 || rd1_ready !== 1'b0 || rsp_valid !== 1'b0 || csb1 !== 1'b1) bad++;
    end
    n_checks++;
    if (done_i < 0) begin
      n_errors++; $display("FAIL init_timeout: init_done never rose within 1100 cycles");
    end
    n_checks++;
    if (wr != 1024 || bad != 0) begin
      n_errors++; $display("FAIL init_writes: got %0d writes %0d bad cycles expected 1024 writes 0 bad", wr, bad);
    end
    n_checks++;
    if (done_i != last_i + 1 || csb0_at_done !== 1'b1 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL init_done_timing: done at %0d last write at %0d csb0 %b ready %b expected done=last+1 csb0 1 ready 1",
               done_i, last_i, csb0_at_done, req_ready);
    end
    // zero-filled read of 0x155
    p0_req(1'b0, 10'h155, 32'h0, 4'h0);
    tick;
    p0_idle();
    n_checks++;
    if ({csb0, web0, wmask0, addr0} !== {1'b0, 1'b1, 4'hF, 10'h155}) begin
      n_errors++; $display("FAIL read_pins: got %b %b %h %h expected 0 1 f 155", csb0, web0, wmask0, addr0);
    end
    tick;
    n_checks++;
    if (rsp_valid !== 1'b0 || csb0 !== 1'b1 || web0 !== 1'b1 || wmask0 !== 4'h0 || addr0 !== 10'h155) begin
      n_errors++; $display("FAIL idle_pins: got rsp_valid %b csb0 %b web0 %b wmask %h addr %h expected 0 1 1 0 155",
                           rsp_valid, csb0, web0, wmask0, addr0);
    end
    tick;
    n_checks++;
    if ({rsp_valid, rsp_we, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_errors++; $display("FAIL read_155: got valid %b we %b data %h expected 1 0 00000000", rsp_valid, rsp_we, rsp_rdata);
    end
    tick;
  endtask

  task automatic test_write_mask;
    p0_req(1'b1, 10'h3FF, 32'h1234_5678, 4'hF);
    tick;
    n_checks++;
    if ({csb0, web0, wmask0, addr0, din0} !== {1'b0, 1'b0, 4'hF, 10'h3FF, 32'h1234_5678}) begin
      n_errors++; $display("FAIL wr_full_pins: got %b %b %h %h %h", csb0, web0, wmask0, addr0, din0);
    end
    p0_req(1'b1, 10'h3FF, 32'h0000_00AA, 4'b0001);
    tick;
    n_checks++;
    if ({csb0, web0, wmask0, din0} !== {1'b0, 1'b0, 4'h1, 32'h0000_00AA}) begin
      n_errors++; $display("FAIL wr_byte_pins: got %b %b %h %h expected 0 0 1 000000aa", csb0, web0, wmask0, din0);
    end
    p0_req(1'b0, 10'h3FF, 32'h0, 4'h0);
    tick;
    p0_idle();
    n_checks++;
    if ({rsp_valid, rsp_we, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      n_errors++; $display("FAIL ack1: got %b %b %h expected 1 1 00000000", rsp_valid, rsp_we, rsp_rdata);
    end
    tick;
    n_checks++;
    if ({rsp_valid, rsp_we} !== 2'b11) begin
      n_errors++; $display("FAIL ack2: got %b %b expected 1 1", rsp_valid, rsp_we);
    end
    tick;
    n_checks++;
    if ({rsp_valid, rsp_we, rsp_rdata} !== {1'b1, 1'b0, 32'h1234_56AA}) begin
      n_errors++; $display("FAIL read_merged: got %b %b %h expected 1 0 123456aa", rsp_valid, rsp_we, rsp_rdata);
    end
    tick;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL rsp_pulse_width: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic        we_v [6]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [9:0]  ad_v [6]   = '{10'd1, 10'd2, 10'd3, 10'd1, 10'd2, 10'd3};
    logic [31:0] dt_v [6]   = '{32'h1111, 32'h2222, 32'h3333, 32'h1111, 32'h2222, 32'h3333};
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) p0_req(we_v[i], ad_v[i], dt_v[i], 4'hF);
      else p0_idle();
      tick;
      if (i >= 2) begin
        if (rsp_valid !== 1'b1 || rsp_we !== we_v[i-2] || (!we_v[i-2] && rsp_rdata !== dt_v[i-2])) begin
          bad++;
          $display("FAIL b2b_rsp%0d: got valid %b we %b data %h expected 1 %b %h",
                   i - 2, rsp_valid, rsp_we, rsp_rdata, we_v[i-2], dt_v[i-2]);
        end
      end
    end
    n_checks++;
    if (bad != 0) n_errors++;
    tick;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_tail: got valid %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_collision;
    p0_req(1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF);
    rd1_valid = 1'b1; rd1_addr = 10'h010;
    #1;
    n_checks++;
    if ({req_ready, rd1_ready} !== 2'b10) begin
      n_errors++; $display("FAIL collide_ready: got %b%b expected 10", req_ready, rd1_ready);
    end
    tick;
    p0_idle();
    #1;
    n_checks++;
    if ({rd1_ready, csb1} !== 2'b11) begin
      n_errors++; $display("FAIL collide_retry: got ready %b csb1 %b expected 1 1", rd1_ready, csb1);
    end
    tick;
    rd1_valid = 1'b0;
    n_checks++;
    if ({csb1, addr1} !== {1'b0, 10'h010}) begin
      n_errors++; $display("FAIL rd1_pins: got %b %h expected 0 010", csb1, addr1);
    end
    tick;
    tick;
    n_checks++;
    if ({rd1_rsp_valid, rd1_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_errors++; $display("FAIL rd1_new_data: got %b %h expected 1 deadbeef", rd1_rsp_valid, rd1_rdata);
    end
    tick;
    // simultaneous reads of one address from both ports
    p0_req(1'b0, 10'h3FF, 32'h0, 4'h0);
    rd1_valid = 1'b1; rd1_addr = 10'h3FF;
    #1;
    n_checks++;
    if ({req_ready, rd1_ready} !== 2'b11) begin
      n_errors++; $display("FAIL dual_read_ready: got %b%b expected 11", req_ready, rd1_ready);
    end
    tick;
    p0_idle(); rd1_valid = 1'b0;
    tick; tick;
    n_checks++;
    if ({rsp_valid, rsp_rdata, rd1_rsp_valid, rd1_rdata} !== {1'b1, 32'h1234_56AA, 1'b1, 32'h1234_56AA}) begin
      n_errors++; $display("FAIL dual_read: got %b %h %b %h expected 1 123456aa 1 123456aa",
                           rsp_valid, rsp_rdata, rd1_rsp_valid, rd1_rdata);
    end
    tick;
  endtask

  task automatic test_be_zero;
    p0_req(1'b1, 10'h020, 32'hFFFF_FFFF, 4'h0);
    tick;
    p0_idle();
    n_checks++;
    if ({csb0, wmask0} !== {1'b1, 4'h0}) begin
      n_errors++; $display("FAIL be0_pins: got csb0 %b wmask %h expected 1 0", csb0, wmask0);
    end
    p0_req(1'b0, 10'h020, 32'h0, 4'h0);
    tick;
    p0_idle();
    tick;
    n_checks++;
    if ({rsp_valid, rsp_we} !== 2'b11) begin
      n_errors++; $display("FAIL be0_ack: got %b %b expected 1 1", rsp_valid, rsp_we);
    end
    tick;
    n_checks++;
    if ({rsp_valid, rsp_we, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_errors++; $display("FAIL be0_unchanged: got %b %b %h expected 1 0 00000000", rsp_valid, rsp_we, rsp_rdata);
    end
    tick;
  endtask

  task automatic test_reset_mid_init;
    logic [126:0] obs;
    int bad = 0, hit = 0, done = 0;
    p0_req(1'b0, 10'h3FF, 32'h0, 4'h0);
    tick;
    p0_idle();
    rst_n = 1'b0;
    #1;
    obs = rst_obs();
    n_checks++;
    if (obs !== RST_VEC) begin
      n_errors++; $display("FAIL async_reset_run: got %h expected %h", obs, RST_VEC);
    end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick;
      if (rsp_valid !== 1'b0 || rd1_rsp_valid !== 1'b0) bad++;
      if (csb0 === 1'b0 && addr0 === 10'd500) begin hit = 1; break; end
    end
    n_checks++;
    if (hit != 1 || bad != 0) begin
      n_errors++; $display("FAIL reinit_to_500: got reached %0d stray pulses %0d expected 1 0", hit, bad);
    end
    rst_n = 1'b0;
    #1;
    obs = rst_obs();
    n_checks++;
    if (obs !== RST_VEC) begin
      n_errors++; $display("FAIL async_reset_init: got %h expected %h", obs, RST_VEC);
    end
    tick;
    rst_n = 1'b1;
    tick;
    n_checks++;
    if ({csb0, addr0, rsp_valid} !== {1'b0, 10'h0, 1'b0}) begin
      n_errors++; $display("FAIL init_restart: got csb0 %b addr %h valid %b expected 0 000 0", csb0, addr0, rsp_valid);
    end
    for (int i = 0; i < 1100; i++) begin
      tick;
      if (init_done === 1'b1) begin done = 1; break; end
    end
    n_checks++;
    if (done != 1) begin
      n_errors++; $display("FAIL reinit_timeout: init_done got %b expected 1", init_done);
    end
    p0_req(1'b0, 10'h3FF, 32'h0, 4'h0);
    tick;
    p0_idle();
    tick; tick;
    n_checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0}) begin
      n_errors++; $display("FAIL reinit_zero: got %b %h expected 1 00000000", rsp_valid, rsp_rdata);
    end
    tick;
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_mask();
    test_back_to_back();
    test_collision();
    test_be_zero();
    test_reset_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
